// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master to one-slave bus arbiter. Master 0 is the CPU side and master 1
// is the DMA side; the slave side feeds the memory mapper. A request is
// mX_rd | mX_we. In IDLE the arbiter picks one requester, and it grants on the
// next edge. While granted, the master's address, data and strobes pass
// straight through to the slave, and s_spo/s_ready pass back to the master.
// A wait counter limits how long a grant can wait for s_ready. When the limit
// is reached, the master gets a ready with the 32'hDEADBEEF error pattern and
// the arbiter raises err_irq.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of cycles a grant waits for s_ready
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_a/m0_d/m0_we/m0_rd         master 0 request (inputs)
//   m0_spo/m0_ready               master 0 response (outputs)
//   m1_a/m1_d/m1_we/m1_rd         master 1 request (inputs)
//   m1_spo/m1_ready               master 1 response (outputs)
//   s_a/s_d/s_we/s_rd             slave request (outputs)
//   s_spo/s_ready                 slave response (inputs)
//   err_irq                       one-cycle timeout pulse (registered)
//   err_master                    index of the master that last timed out
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate between
//                       the masters. When undefined, master 0 always wins.
//
// err_irq and err_master are registered. They become visible in the cycle
// after the timeout cycle, which is the cycle in which the master sees the
// error ready.
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        err_irq,
  output logic        err_master
);

  localparam int CNT_W_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_MIN > 10) ? CNT_W_MIN : 10;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]      ERR_SPO     = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_irq_q, err_irq_d;
  logic             err_master_q, err_master_d;
`ifdef ARB_ROUND_ROBIN_EN
  // Master preferred on the next tie. It points away from the last grant.
  logic             rr_q, rr_d;
`endif

  logic m0_req_s;
  logic m1_req_s;
  logic pick0_s;
  logic grant_req_s;
  logic timeout_s;

  assign m0_req_s = m0_rd | m0_we;
  assign m1_req_s = m1_rd | m1_we;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick0_s = m0_req_s & (~m1_req_s | ~rr_q);
`else
  assign pick0_s = m0_req_s;
`endif

  // Request of the currently granted master and timeout detection
  always_comb begin
    grant_req_s = 1'b0;
    case (state_q)
      GRANT0:  grant_req_s = m0_req_s;
      GRANT1:  grant_req_s = m1_req_s;
      default: grant_req_s = 1'b0;
    endcase
    // An abort (request dropped) or a late s_ready takes precedence over the timeout.
    timeout_s = grant_req_s & ~s_ready & (cnt_q == TIMEOUT_VAL);
  end

  // Next-state, wait counter and error register computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_irq_d    = 1'b0;
    err_master_d = err_master_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick0_s) begin
          state_d = GRANT0;
          cnt_d   = {CNT_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = 1'b1;
`endif
        end else if (m1_req_s) begin
          state_d = GRANT1;
          cnt_d   = {CNT_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (!grant_req_s || s_ready) begin
          state_d = IDLE;
        end else if (timeout_s) begin
          state_d      = IDLE;
          err_irq_d    = 1'b1;
          err_master_d = (state_q == GRANT1);
        end else if (cnt_q != TIMEOUT_VAL) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;  // saturate, never wrap
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for the FSM, counter and error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      err_irq_q    <= 1'b0;
      err_master_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_irq_q    <= err_irq_d;
      err_master_q <= err_master_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q         <= rr_d;
`endif
    end
  end

  // Combinational pass-through between the granted master and the slave
  always_comb begin
    s_a      = 32'h0000_0000;
    s_d      = 32'h0000_0000;
    s_we     = 1'b0;
    s_rd     = 1'b0;
    m0_spo   = 32'h0000_0000;
    m0_ready = 1'b0;
    m1_spo   = 32'h0000_0000;
    m1_ready = 1'b0;
    case (state_q)
      GRANT0: begin
        s_a      = m0_a;
        s_d      = m0_d;
        s_we     = m0_we & ~timeout_s;
        s_rd     = m0_rd & ~timeout_s;
        m0_spo   = timeout_s ? ERR_SPO : s_spo;
        m0_ready = timeout_s | s_ready;
      end
      GRANT1: begin
        s_a      = m1_a;
        s_d      = m1_d;
        s_we     = m1_we & ~timeout_s;
        s_rd     = m1_rd & ~timeout_s;
        m1_spo   = timeout_s ? ERR_SPO : s_spo;
        m1_ready = timeout_s | s_ready;
      end
      default: begin
        s_a = 32'h0000_0000;
      end
    endcase
  end

  assign err_irq    = err_irq_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 8). A transaction-level
// model tracks which master owns the bus and how long it has waited. Every
// cycle, every DUT output is compared with the model. Directed sequences come
// first, followed by a randomized run of protocol-abiding masters.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic        mrd [2];
  logic        mwe [2];
  logic [31:0] m0_spo, m1_spo, s_a, s_d, s_spo;
  logic        m0_ready, m1_ready, s_we, s_rd, s_ready, err_irq, err_master;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_a(ma[0]), .m0_d(md[0]), .m0_we(mwe[0]), .m0_rd(mrd[0]),
    .m0_spo(m0_spo), .m0_ready(m0_ready),
    .m1_a(ma[1]), .m1_d(md[1]), .m1_we(mwe[1]), .m1_rd(mrd[1]),
    .m1_spo(m1_spo), .m1_ready(m1_ready),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
    .s_spo(s_spo), .s_ready(s_ready),
    .err_irq(err_irq), .err_master(err_master)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: bus owner (-1 = nobody), wait cycles of the current grant,
  // tie-break preference, and the registered error outputs.
  int owner = -1, waited = 0, rr = 0;
  bit e_irq = 1'b0, e_em = 1'b0;
  int n_owner, n_waited, n_rr;
  bit n_irq, n_em;
  bit done [2];

  // Check the combinational outputs mid-cycle and compute the model's next state.
  task automatic settle();
    logic [31:0] e_sa, e_sd;
    logic        e_swe, e_srd;
    logic [31:0] e_spo [2];
    logic        e_rdy [2];
    bit          req, to, r0, r1;
    int          pick;
    #4;
    e_sa = 32'h0; e_sd = 32'h0; e_swe = 1'b0; e_srd = 1'b0;
    e_spo[0] = 32'h0; e_spo[1] = 32'h0; e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    req = 1'b0; to = 1'b0;
    if (owner >= 0) begin
      req  = mrd[owner] | mwe[owner];
      to   = req && !s_ready && (waited == TO);
      e_sa = ma[owner];
      e_sd = md[owner];
      e_swe = to ? 1'b0 : mwe[owner];
      e_srd = to ? 1'b0 : mrd[owner];
      e_spo[owner] = to ? 32'hDEADBEEF : s_spo;
      e_rdy[owner] = to ? 1'b1 : s_ready;
    end
    check_val("s_a", s_a, e_sa);
    check_val("s_d", s_d, e_sd);
    check_val("s_we", {31'd0, s_we}, {31'd0, e_swe});
    check_val("s_rd", {31'd0, s_rd}, {31'd0, e_srd});
    check_val("m0_spo", m0_spo, e_spo[0]);
    check_val("m1_spo", m1_spo, e_spo[1]);
    check_val("m0_ready", {31'd0, m0_ready}, {31'd0, e_rdy[0]});
    check_val("m1_ready", {31'd0, m1_ready}, {31'd0, e_rdy[1]});
    done[0] = e_rdy[0];
    done[1] = e_rdy[1];
    n_owner = owner; n_waited = waited; n_rr = rr; n_irq = 1'b0; n_em = e_em;
    if (rst) begin
      n_owner = -1; n_waited = 0; n_rr = 0; n_em = 1'b0;
    end else if (owner < 0) begin
      r0 = mrd[0] | mwe[0];
      r1 = mrd[1] | mwe[1];
      pick = -1;
      if (r0 && r1) pick = RR_MODE ? rr : 0;
      else if (r0) pick = 0;
      else if (r1) pick = 1;
      if (pick >= 0) begin
        n_owner = pick; n_waited = 0; n_rr = 1 - pick;
      end
    end else begin
      if (!req || s_ready) n_owner = -1;
      else if (to) begin
        n_owner = -1; n_irq = 1'b1; n_em = (owner == 1);
      end else n_waited = (waited < TO) ? waited + 1 : waited;
    end
  endtask

  // Take the clock edge, commit the model, and check the registered outputs.
  task automatic advance();
    @(posedge clk);
    #1;
    owner = n_owner; waited = n_waited; rr = n_rr; e_irq = n_irq; e_em = n_em;
    check_val("err_irq", {31'd0, err_irq}, {31'd0, e_irq});
    check_val("err_master", {31'd0, err_master}, {31'd0, e_em});
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle_masters();
    for (int i = 0; i < 2; i++) begin
      mrd[i] = 1'b0; mwe[i] = 1'b0; ma[i] = 32'h0; md[i] = 32'h0;
    end
  endtask

  initial begin
    bit busy [2];
    int slow;
    rst = 1'b1; s_ready = 1'b0; s_spo = 32'h0;
    idle_masters();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_err_irq", {31'd0, err_irq}, 32'd0);
    check_val("rst_err_master", {31'd0, err_master}, 32'd0);
    cycle();

    // Single read; the request is made right after reset release.
    ma[0] = 32'h8000_0010; mrd[0] = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      settle();
      check_val("rd_s_rd", {31'd0, s_rd}, 32'd1);
      check_val("rd_s_a", s_a, 32'h8000_0010);
      advance();
    end
    s_ready = 1'b1; s_spo = 32'h1234_5678;
    settle();
    check_val("rd_ready", {31'd0, m0_ready}, 32'd1);
    check_val("rd_spo", m0_spo, 32'h1234_5678);
    advance();
    mrd[0] = 1'b0; s_ready = 1'b1;  // s_ready in IDLE must be ignored
    settle();
    check_val("rd_idle_ready", {31'd0, m0_ready}, 32'd0);
    advance();
    s_ready = 1'b0;

    // Contention: master 0 wins, and master 1 follows after one IDLE cycle.
    ma[0] = 32'h0000_0100; mrd[0] = 1'b1;
    ma[1] = 32'h0000_0200; md[1] = 32'hA5A5_0001; mwe[1] = 1'b1;
    cycle();
    settle();
    check_val("ct_grant0", s_a, 32'h0000_0100);
    check_val("ct_m1_wait", {31'd0, m1_ready}, 32'd0);
    advance();
    s_ready = 1'b1; s_spo = 32'h0BAD_F00D;
    settle();
    check_val("ct_m1_wait2", {31'd0, m1_ready}, 32'd0);
    advance();
    mrd[0] = 1'b0; s_ready = 1'b0;
    settle();
    check_val("ct_idle_gap", {31'd0, s_we}, 32'd0);
    advance();
    s_ready = 1'b1;
    settle();
    check_val("ct_grant1_we", {31'd0, s_we}, 32'd1);
    check_val("ct_grant1_d", s_d, 32'hA5A5_0001);
    advance();
    mwe[1] = 1'b0; s_ready = 1'b0;
    cycle();

    // Timeout on master 1.
    ma[1] = 32'h0000_0300; mrd[1] = 1'b1;
    cycle();
    for (int k = 0; k < TO; k++) begin
      settle();
      check_val("to_wait", {31'd0, m1_ready}, 32'd0);
      advance();
    end
    settle();
    check_val("to_ready", {31'd0, m1_ready}, 32'd1);
    check_val("to_spo", m1_spo, 32'hDEAD_BEEF);
    check_val("to_s_rd", {31'd0, s_rd}, 32'd0);
    advance();
    check_val("to_irq", {31'd0, err_irq}, 32'd1);
    check_val("to_master", {31'd0, err_master}, 32'd1);
    mrd[1] = 1'b0;
    cycle();
    check_val("to_irq_once", {31'd0, err_irq}, 32'd0);

    // s_ready in the same cycle as the counter limit completes normally.
    ma[0] = 32'h0000_0400; mrd[0] = 1'b1;
    cycle();
    repeat (TO) cycle();
    s_ready = 1'b1; s_spo = 32'hCAFE_F00D;
    settle();
    check_val("edge_spo", m0_spo, 32'hCAFE_F00D);
    advance();
    check_val("edge_no_irq", {31'd0, err_irq}, 32'd0);
    mrd[0] = 1'b0; s_ready = 1'b0;
    cycle();

    // Abort: master 0 drops its write after two grant cycles.
    ma[0] = 32'h0000_0500; md[0] = 32'h1111_2222; mwe[0] = 1'b1;
    repeat (3) cycle();
    mwe[0] = 1'b0;
    cycle();
    check_val("ab_no_irq", {31'd0, err_irq}, 32'd0);
    settle();
    check_val("ab_idle", s_a, 32'h0);
    advance();

    // Reset in the middle of a GRANT1 write, then a normal master 0 read.
    ma[1] = 32'h0000_0600; mwe[1] = 1'b1;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; mwe[1] = 1'b0;
    ma[0] = 32'h0000_0700; mrd[0] = 1'b1;
    settle();
    check_val("rs_s_we", {31'd0, s_we}, 32'd0);
    check_val("rs_m1_ready", {31'd0, m1_ready}, 32'd0);
    advance();
    s_ready = 1'b1; s_spo = 32'h7777_0000;
    settle();
    check_val("rs_regrant", s_a, 32'h0000_0700);
    check_val("rs_ready", {31'd0, m0_ready}, 32'd1);
    advance();
    mrd[0] = 1'b0; s_ready = 1'b0;

    // Continuous requests from both masters. In round-robin mode the grants alternate.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ma[0] = 32'h0000_0A00; mrd[0] = 1'b1;
    ma[1] = 32'h0000_0B00; mrd[1] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      s_ready = 1'b0;
      cycle();
      settle();
      check_val("rr_order", s_a, (RR_MODE && (g % 2 == 1)) ? 32'h0000_0B00 : 32'h0000_0A00);
      advance();
      s_ready = 1'b1;
      cycle();
    end
    idle_masters(); s_ready = 1'b0;
    cycle();

    // Randomized run.
    busy[0] = 1'b0; busy[1] = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i] && (done[i] || $urandom_range(0, 49) == 0)) begin
          busy[i] = 1'b0; mrd[i] = 1'b0; mwe[i] = 1'b0;
        end
        if (!busy[i] && $urandom_range(0, 2) == 0) begin
          busy[i] = 1'b1;
          ma[i] = $urandom; md[i] = $urandom;
          mrd[i] = ($urandom_range(0, 1) == 1);
          mwe[i] = !mrd[i];
        end
      end
      slow = (cyc / 200) % 2;
      s_ready = ($urandom_range(0, (slow == 1) ? 15 : 2) == 0);
      s_spo = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; s_ready = 1'b0;
    idle_masters();
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the maximum number of cycles a grant waits for s_ready.
REQ-002 SHALL have port clk, input, 1 bit: sole clock (clk_main domain).
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have master 0 (CPU side) ports: m0_a in 32, m0_d in 32, m0_we in 1, m0_rd in 1, m0_spo out 32, m0_ready out 1.
REQ-005 SHALL have master 1 (DMA side) ports: m1_a in 32, m1_d in 32, m1_we in 1, m1_rd in 1, m1_spo out 32, m1_ready out 1.
REQ-006 SHALL have slave ports to mmapper: s_a out 32, s_d out 32, s_we out 1, s_rd out 1, s_spo in 32, s_ready in 1.
REQ-007 SHALL have port err_irq, output, 1 bit: one-cycle pulse on a bus timeout.
REQ-008 SHALL have port err_master, output, 1 bit: registered index of the master that last timed out.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-010 SHALL treat mX_req = mX_rd | mX_we as a request; a master SHALL hold a, d, rd and we stable until it sees mX_ready.
REQ-011 In IDLE, SHALL drive s_a=0, s_d=0, s_we=0, s_rd=0, m0_ready=0, m1_ready=0, m0_spo=0 and m1_spo=0.
REQ-012 In IDLE with exactly one request, SHALL enter GRANTx for that master on the next edge (one cycle arbitration latency).
REQ-013 In IDLE with both requests, SHALL grant master 0 (fixed priority) unless ARB_ROUND_ROBIN_EN is defined (REQ-027).
REQ-014 In GRANTx, SHALL combinationally forward mX_a, mX_d, mX_we and mX_rd to the slave, s_spo to mX_spo, and s_ready to mX_ready.
REQ-015 In GRANTx, the non-granted master SHALL see ready=0 and spo=0, and its request SHALL remain pending.
REQ-016 In GRANTx, SHALL return to IDLE on the edge after the cycle where s_ready=1; the next grant SHALL follow at least one IDLE cycle later.
REQ-017 In GRANTx, if mX_req drops before s_ready (abort), SHALL return to IDLE on the next edge with no error.
REQ-018 SHALL hold a 10-bit-minimum wait counter (width clog2(TIMEOUT_CYCLES+1)) that clears on entry to GRANTx and increments each GRANTx cycle with s_ready=0.
REQ-019 When the counter equals TIMEOUT_CYCLES with s_ready=0, SHALL for that one cycle drive mX_ready=1 and mX_spo=32'hDEADBEEF, force s_rd=s_we=0, pulse err_irq, set err_master=X, and go to IDLE.
REQ-020 If s_ready=1 in the same cycle the counter hits TIMEOUT_CYCLES, SHALL complete normally with no error.
REQ-021 The counter SHALL saturate and never wrap.
REQ-022 s_ready while in IDLE SHALL be ignored.

Reset
REQ-023 Reset SHALL set state=IDLE, wait counter=0, err_irq=0, err_master=0 and round-robin pointer=0.
REQ-024 Reset asserted mid-grant SHALL abort the transfer, with all slave strobes and master readies low from the following cycle.
REQ-025 After reset release, SHALL accept requests in the first cycle.

Configuration
REQ-026 SHALL compile round-robin arbitration under macro ARB_ROUND_ROBIN_EN.
REQ-027 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the master that was not granted last (pointer updated on each grant, reset to favour master 0); single requests SHALL be unaffected.
REQ-028 Without ARB_ROUND_ROBIN_EN: SHALL use fixed priority to master 0, with no pointer register present.

Verification
REQ-029 Single read: m0_rd=1 @0x80000010, slave s_ready after 3 cycles with s_spo=0x12345678 -> m0_ready=1 with m0_spo=0x12345678 in that cycle, s_rd high for 3 cycles after the grant, then IDLE.
REQ-030 Contention, fixed priority: m0_rd and m1_we asserted in the same cycle -> GRANT0 first; m1 served after m0 completes plus one IDLE cycle; m1_ready=0 throughout m0's grant.
REQ-031 Contention under ARB_ROUND_ROBIN_EN: both masters requesting continuously, s_ready=1 after 1 cycle -> grants alternate 0,1,0,1.
REQ-032 Timeout: TIMEOUT_CYCLES=8, m1_rd, s_ready held 0 -> m1_ready=1, m1_spo=0xDEADBEEF, err_irq pulsed once and err_master=1, all 8 wait cycles after the grant.
REQ-033 Abort and reset: m0_we dropped after 2 grant cycles -> IDLE with no err_irq; separately, rst pulsed mid-GRANT1 -> IDLE, s_we=0 next cycle, and a new m0 request is granted normally.
